// File: rtl/carrega_pkg.sv
// Shared definitions for the instruction loader.
// Holds the 4-bit FSM state encoding (same width as the processor's estado bus),
// the byte/word width constants and the byte-order constant used by the word assembler.
// Optional feature macro: CARREGA_CHECKSUM_EN adds the StVerifica state.
package carrega_pkg;

  localparam int unsigned LarguraByte     = 8;
  localparam int unsigned LarguraPalavra  = 32;
  localparam int unsigned BytesPorPalavra = LarguraPalavra / LarguraByte;
  localparam int unsigned LarguraIndice   = 2;
  localparam int unsigned LarguraEstado   = 4;

  // First byte of the stream lands in the most significant byte of the word.
  localparam bit OrdemBigEndian = 1'b1;

  typedef enum logic [LarguraEstado-1:0] {
    StOcioso    = 4'd0,
    StRecebe    = 4'd1,
    StEscreve   = 4'd2,
    StConcluido = 4'd3
`ifdef CARREGA_CHECKSUM_EN
    ,
    StVerifica  = 4'd4
`endif
  } estado_t;

endpackage

// File: rtl/montador_palavra.sv
// Word assembler: shifts accepted bytes into a 32-bit word and tracks the byte index.
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset
//   limpa_i    clear the byte index (start of session, after a write, on end of stream)
//   aceita_i   a byte is accepted this cycle
//   byte_i     byte to shift in
//   palavra_o  assembled word register
//   indice_o   number of bytes already held for the current word (0-3)
//   completa_o this acceptance completes a word
module montador_palavra
  import carrega_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      limpa_i,
  input  logic                      aceita_i,
  input  logic [LarguraByte-1:0]    byte_i,
  output logic [LarguraPalavra-1:0] palavra_o,
  output logic [LarguraIndice-1:0]  indice_o,
  output logic                      completa_o
);

  logic [LarguraPalavra-1:0] palavra_q, palavra_d;
  logic [LarguraIndice-1:0]  indice_q, indice_d;

  always_comb begin
    palavra_d = palavra_q;
    indice_d  = indice_q;
    if (aceita_i) begin
      palavra_d = OrdemBigEndian ?
                  {palavra_q[LarguraPalavra-LarguraByte-1:0], byte_i} :
                  {byte_i, palavra_q[LarguraPalavra-1:LarguraByte]};
      indice_d  = indice_q + 2'd1;
    end
    // Clear wins: a word is never carried across a write or a session boundary.
    if (limpa_i) begin
      indice_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      palavra_q <= '0;
      indice_q  <= '0;
    end else begin
      palavra_q <= palavra_d;
      indice_q  <= indice_d;
    end
  end

  assign palavra_o  = palavra_q;
  assign indice_o   = indice_q;
  assign completa_o = aceita_i && (indice_q == LarguraIndice'(BytesPorPalavra - 1));

endmodule

// File: rtl/carrega_instrucao.sv
// Instruction loader: receives a host byte stream, packs it big-endian into 32-bit words
// and writes them to consecutive word addresses of the instruction memory.
// Optional feature macro: CARREGA_CHECKSUM_EN -- after a clean end of stream one more
// byte is taken and compared with the XOR of all data bytes; a mismatch sets erro.
// Ports:
//   clk, reset (sync, active-high)
//   inicio       one-cycle pulse starting a load session
//   byte_in      stream byte, qualified by byte_valido
//   fim          one-cycle end-of-stream pulse (has priority over byte_valido)
//   byte_pronto  loader accepts a byte this cycle
//   mem_we/mem_end/mem_dado  instruction-memory write port (word addressing)
//   palavras     words written this session
//   carregado    load complete
//   erro         partial word at end of stream or bad checksum
module carrega_instrucao
  import carrega_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inicio,
  input  logic [LarguraByte-1:0]    byte_in,
  input  logic                      byte_valido,
  input  logic                      fim,
  output logic                      byte_pronto,
  output logic                      mem_we,
  output logic [LarguraPalavra-1:0] mem_end,
  output logic [LarguraPalavra-1:0] mem_dado,
  output logic [LarguraPalavra-1:0] palavras,
  output logic                      carregado,
  output logic                      erro
);

`ifdef CARREGA_CHECKSUM_EN
  localparam estado_t EstFimLimpo = StVerifica;
`else
  localparam estado_t EstFimLimpo = StConcluido;
`endif

  localparam logic [LarguraPalavra-1:0] UltimoEnd = LarguraPalavra'(PROFUNDIDADE - 1);

  estado_t                   estado_q, estado_d;
  logic [LarguraPalavra-1:0] cont_q, cont_d;     // next address == words written
  logic                      erro_q, erro_d;
  logic [LarguraPalavra-1:0] end_q, dado_q;      // last write, held outside StEscreve
`ifdef CARREGA_CHECKSUM_EN
  logic [LarguraByte-1:0]    xor_q, xor_d;
`endif

  logic                      aceita, limpa, completa;
  logic [LarguraPalavra-1:0] palavra;
  logic [LarguraIndice-1:0]  indice;

  montador_palavra u_montador (
    .clk_i      (clk),
    .reset_i    (reset),
    .limpa_i    (limpa),
    .aceita_i   (aceita),
    .byte_i     (byte_in),
    .palavra_o  (palavra),
    .indice_o   (indice),
    .completa_o (completa)
  );

  always_comb begin
    estado_d    = estado_q;
    cont_d      = cont_q;
    erro_d      = erro_q;
    aceita      = 1'b0;
    limpa       = 1'b0;
    byte_pronto = 1'b0;
`ifdef CARREGA_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    case (estado_q)
      // A finished session behaves like idle for a new inicio.
      StOcioso, StConcluido: begin
        if (inicio) begin
          estado_d = StRecebe;
          cont_d   = '0;
          erro_d   = 1'b0;
          limpa    = 1'b1;
`ifdef CARREGA_CHECKSUM_EN
          xor_d    = '0;
`endif
        end
      end
      StRecebe: begin
        byte_pronto = 1'b1;
        if (fim) begin
          limpa = 1'b1;
          if (indice != '0) begin
            // Partial word is dropped; no checksum phase after a broken stream.
            estado_d = StConcluido;
            erro_d   = 1'b1;
          end else begin
            estado_d = EstFimLimpo;
          end
        end else if (byte_valido) begin
          aceita = 1'b1;
`ifdef CARREGA_CHECKSUM_EN
          xor_d  = xor_q ^ byte_in;
`endif
          if (completa) begin
            estado_d = StEscreve;
          end
        end
      end
      StEscreve: begin
        limpa    = 1'b1;
        cont_d   = cont_q + 1'b1;
        estado_d = (cont_q == UltimoEnd) ? EstFimLimpo : StRecebe;
      end
`ifdef CARREGA_CHECKSUM_EN
      StVerifica: begin
        byte_pronto = 1'b1;
        if (byte_valido) begin
          erro_d   = (byte_in != xor_q);
          estado_d = StConcluido;
        end
      end
`endif
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= StOcioso;
      cont_q   <= '0;
      erro_q   <= 1'b0;
      end_q    <= '0;
      dado_q   <= '0;
`ifdef CARREGA_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      erro_q   <= erro_d;
      if (estado_q == StEscreve) begin
        end_q  <= cont_q;
        dado_q <= palavra;
      end
`ifdef CARREGA_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign mem_we    = (estado_q == StEscreve);
  assign mem_end   = mem_we ? cont_q : end_q;
  assign mem_dado  = mem_we ? palavra : dado_q;
  assign palavras  = cont_q;
  assign carregado = (estado_q == StConcluido);
  assign erro      = erro_q;

endmodule

// File: tb/tb_carrega_instrucao.sv
// Scoreboard bench for carrega_instrucao: the stimulus side pushes expected writes
// (address, word, cycle) computed from the byte stream; a monitor pops and compares
// whenever mem_we is seen. Session-level results are checked after each session.
module tb_carrega_instrucao;

  localparam int DEPTH = 15;
`ifdef CARREGA_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int PhRecv = 0, PhVerify = 1, PhDone = 2;

  logic        clk = 1'b0;
  logic        reset, inicio, byte_valido, fim;
  logic [7:0]  byte_in;
  logic        byte_pronto, mem_we, carregado, erro;
  logic [31:0] mem_end, mem_dado, palavras;

  carrega_instrucao #(.PROFUNDIDADE(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .inicio      (inicio),
    .byte_in     (byte_in),
    .byte_valido (byte_valido),
    .fim         (fim),
    .byte_pronto (byte_pronto),
    .mem_we      (mem_we),
    .mem_end     (mem_end),
    .mem_dado    (mem_dado),
    .palavras    (palavras),
    .carregado   (carregado),
    .erro        (erro)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: mem_we=%b end=%h dado=%h (cycle %0d)",
                 mem_we, mem_end, mem_dado, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_end", mem_end, e.addr);
        check("write_dado", mem_dado, e.data);
        check("write_cycle", cyc, e.cyc);
      end
    end
  end

  // Reference model of the session, advanced byte by byte.
  int          m_nacc, m_words, m_phase;
  logic [31:0] m_word;
  logic [7:0]  m_xor;
  logic        m_erro;
  logic [31:0] last_addr, last_data;
  bit          have_last = 1'b0;

  logic [7:0] s_req036[8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; inicio = 1'b0; fim = 1'b0; byte_valido = 1'b0; byte_in = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    have_last = 1'b0;
    m_phase = PhDone;
    check("rst_byte_pronto", byte_pronto, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_end", mem_end, 0);
    check("rst_mem_dado", mem_dado, 0);
    check("rst_palavras", palavras, 0);
    check("rst_carregado", carregado, 0);
    check("rst_erro", erro, 0);
    check("rst_writes_pending", exp_q.size(), 0);
  endtask

  task automatic start_session();
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    m_nacc = 0; m_words = 0; m_word = '0; m_xor = '0; m_erro = 1'b0; m_phase = PhRecv;
    check("inicio_palavras", palavras, 0);
    check("inicio_carregado", carregado, 0);
    check("inicio_erro", erro, 0);
    check("inicio_byte_pronto", byte_pronto, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    idle($urandom_range(0, 1));
    byte_in = b;
    byte_valido = 1'b1;
    @(posedge clk);
    #1;
    byte_valido = 1'b0;
    if (m_phase == PhRecv) begin
      m_word = {m_word[23:0], b};
      m_xor  = m_xor ^ b;
      m_nacc++;
      if (m_nacc % 4 == 0) begin
        exp_q.push_back('{addr: m_words, data: m_word, cyc: cyc});
        last_addr = m_words;
        last_data = m_word;
        have_last = 1'b1;
        m_words++;
        idle(1);  // write cycle: loader is not ready
        if (m_words == DEPTH) m_phase = CHK ? PhVerify : PhDone;
      end
    end else if (m_phase == PhVerify) begin
      m_erro  = (b != m_xor);
      m_phase = PhDone;
    end
  endtask

  task automatic pulse_fim(input bit with_byte);
    fim = 1'b1;
    byte_valido = with_byte;
    byte_in = 8'($urandom);
    @(posedge clk);
    #1;
    fim = 1'b0;
    byte_valido = 1'b0;
    if (m_phase == PhRecv) begin
      if (m_nacc % 4 != 0) begin
        m_erro  = 1'b1;
        m_phase = PhDone;
      end else begin
        m_phase = CHK ? PhVerify : PhDone;
      end
    end
  endtask

  task automatic finish_session(input bit with_fim, input bit fim_byte, input bit chk_good);
    if (with_fim) pulse_fim(fim_byte);
    if (m_phase == PhVerify) send_byte(chk_good ? m_xor : (m_xor ^ 8'h01));
    idle(2);
    check("fim_carregado", carregado, (m_phase == PhDone));
    check("fim_erro", erro, m_erro);
    check("fim_palavras", palavras, m_words);
    check("fim_byte_pronto", byte_pronto, 0);
    check("fim_writes_pending", exp_q.size(), 0);
    if (have_last) begin
      check("hold_mem_end", mem_end, last_addr);
      check("hold_mem_dado", mem_dado, last_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Two full words, clean end.
    start_session();
    foreach (s_req036[i]) send_byte(s_req036[i]);
    finish_session(1'b1, 1'b0, 1'b1);

    // Partial word: no write, error flagged.
    start_session();
    send_byte(8'h12);
    send_byte(8'h34);
    finish_session(1'b1, 1'b0, 1'b1);

    // Four words, then fim together with a byte that must be discarded.
    start_session();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    finish_session(1'b1, 1'b1, 1'b1);

    // Overlong stream: memory fills, trailing bytes ignored.
    start_session();
    for (int i = 0; i < 64; i++) send_byte(8'($urandom));
    finish_session(1'b0, 1'b0, 1'b1);

    // Reset in the middle of word 1, then a fresh session starts at address 0.
    start_session();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    do_reset();
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    finish_session(1'b1, 1'b0, 1'b1);

`ifdef CARREGA_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      start_session();
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      finish_session(1'b1, 1'b0, (k == 0));
    end
`endif

    // Random sessions of random length and end style.
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(0, 30);
      start_session();
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      finish_session(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/carrega_instrucao.md
CARREGA_INSTRUCAO -- requirements
Module: carrega_instrucao

Interface
REQ-001 Parameter PROFUNDIDADE, default 15: number of 32-bit words in the instruction memory being written.
REQ-002 Port clk, input, 1: single clock; all logic on posedge clk.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port inicio, input, 1: one-cycle pulse that starts a load session.
REQ-005 Port byte_in, input, 8: program byte from the host stream.
REQ-006 Port byte_valido, input, 1: byte_in is valid this cycle.
REQ-007 Port fim, input, 1: one-cycle pulse marking end of stream.
REQ-008 Port byte_pronto, output, 1: loader accepts a byte this cycle.
REQ-009 Port mem_we, output, 1: instruction-memory write enable.
REQ-010 Port mem_end, output, 32: word address written; same word-index addressing the fetch side uses as PC.
REQ-011 Port mem_dado, output, 32: instruction word written.
REQ-012 Port palavras, output, 32: count of words written this session.
REQ-013 Port carregado, output, 1: load complete; the processor may start fetching.
REQ-014 Port erro, output, 1: session ended with a partial word or a bad checksum.

Function
REQ-015 The FSM SHALL have states OCIOSO, RECEBE, ESCREVE and CONCLUIDO, plus VERIFICA when the checksum feature is enabled.
REQ-016 OCIOSO: inicio=1 -> RECEBE; on entry, address=0, byte index=0, palavras=0, carregado=0, erro=0; byte_valido and fim are ignored.
REQ-017 RECEBE: byte_pronto=1; a byte is accepted when byte_valido=1.
REQ-018 Each accepted byte SHALL shift into the word big-endian (word <= {word[23:0], byte_in}), so the first byte becomes bits 31:24.
REQ-019 On acceptance of the 4th byte, the next state SHALL be ESCREVE.
REQ-020 ESCREVE lasts exactly one cycle: mem_we=1, mem_end=address, mem_dado=word, byte_pronto=0.
REQ-021 Write latency: mem_we is high in the cycle immediately after the cycle in which the 4th byte was accepted.
REQ-022 After ESCREVE: address and palavras increment by 1; byte index clears; if palavras reaches PROFUNDIDADE -> CONCLUIDO (or VERIFICA), else -> RECEBE.
REQ-023 Address SHALL never exceed PROFUNDIDADE-1; there is no wrap-around.
REQ-024 fim in RECEBE with byte index 0 -> CONCLUIDO (or VERIFICA) with erro=0.
REQ-025 fim in RECEBE with byte index 1-3 -> CONCLUIDO; the partial word is discarded with no write, and erro=1 (no VERIFICA).
REQ-026 If fim and byte_valido are high in the same cycle, fim has priority and the byte is discarded.
REQ-027 CONCLUIDO: carregado=1 and byte_pronto=0, held until reset; inicio restarts a session as from OCIOSO; further bytes are ignored.
REQ-028 Outside ESCREVE, mem_we=0; mem_end and mem_dado hold their last values.

Reset
REQ-029 While reset=1 at a clock edge, the state SHALL go to OCIOSO and every output, the address, the byte index, the word register and the checksum SHALL be cleared to 0.
REQ-030 Reset mid-session SHALL abort the session immediately; no write occurs in the cycle after reset.

Configuration
REQ-031 Macro CARREGA_CHECKSUM_EN SHALL compile the checksum feature in or out.
REQ-032 With CARREGA_CHECKSUM_EN: a running XOR of all accepted data bytes is kept; a clean end enters VERIFICA (byte_pronto=1); the next valid byte is compared with the XOR, mismatch -> erro=1, then -> CONCLUIDO.
REQ-033 Without CARREGA_CHECKSUM_EN: the VERIFICA state and the XOR register do not exist; a clean end goes directly to CONCLUIDO.

Structure
REQ-034 Package carrega_pkg SHALL hold the 4-bit state encoding (same width as the processor's estado bus), the byte/word width constants and the big-endian byte-order constant.
REQ-035 Sub-module montador_palavra SHALL hold the byte shift register and the 2-bit byte index; the FSM, address counter and checksum stay in carrega_instrucao.

Verification
REQ-036 inicio; bytes 00 11 22 33 AA BB CC DD; fim -> writes end 0 = 0x00112233 and end 1 = 0xAABBCCDD; palavras=2; carregado=1; erro=0.
REQ-037 PROFUNDIDADE=15, 64 bytes streamed -> exactly 15 writes (end 0..14); carregado=1 after the 60th byte; bytes 61-64 ignored, with no further mem_we.
REQ-038 inicio; bytes 12 34; fim -> no write; erro=1; carregado=1; palavras=0.
REQ-039 Reset after 3 bytes of word 1 -> all outputs 0; a new inicio plus 4 bytes writes to end 0.
REQ-040 fim and byte_valido high together after 4 full words -> byte discarded; palavras=4; erro=0.
REQ-041 With CARREGA_CHECKSUM_EN: bytes 01 02 03 04, fim, checksum 04 -> erro=0; the same stream with checksum 05 -> erro=1.
